btn_debounce_sync: RTL

//  Input conditioning stage placed directly upstream of the pla block.

---
 rtl/btn_debounce_sync.sv | 96 +++++++++
 1 files changed

// File: rtl/btn_debounce_sync.sv
// Two-flop synchroniser and per-bit stability counter for raw buttons, with rise/fall pulses.
// The toggle output exists only when `DEBOUNCE_TOGGLE_EN is defined; default build omits it.
module btn_debounce_sync #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] btn_toggle
`endif
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]     r_s1;
    logic [WIDTH-1:0]     r_s2;
    logic [WIDTH-1:0]     r_clean;
    logic [WIDTH-1:0]     r_rise;
    logic [WIDTH-1:0]     r_fall;
    logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_done;

    assign w_diff = r_s2 ^ r_clean;

    always_comb begin
        w_done = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_done[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Any cycle where the synchronised level agrees with the accepted one restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_diff[i] && !w_done[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_clean <= r_clean ^ w_done;
            r_rise  <= w_done & r_s2;
            r_fall  <= w_done & ~r_s2;
        end
    end

    assign btn_clean = r_clean;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

`ifdef DEBOUNCE_TOGGLE_EN
    logic [WIDTH-1:0] r_toggle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle <= '0;
        end else begin
            r_toggle <= r_toggle ^ (w_done & r_s2);
        end
    end

    assign btn_toggle = r_toggle;
`endif

endmodule
